// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: issues one I-cache read per cycle, steers the next PC from
// the predictor or an execute redirect, and queues fetched instructions toward decode.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IC_AW    = 8,
  parameter int          META_W   = 24,
  parameter int          Q_DEPTH  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       bp_pc,
  output logic [31:0]       bp_inst,
  output logic              bp_stall,
  input  logic [31:0]       bp_p_target,
  input  logic              bp_p_dir,
  input  logic [META_W-1:0] bp_meta,
  output logic [IC_AW-1:0]  ic_rdaddress,
  input  logic [31:0]       ic_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic              out_p_dir,
  output logic [31:0]       out_p_target,
  output logic [META_W-1:0] out_meta
);

  localparam int CW = $clog2(Q_DEPTH + 1);
  localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(Q_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(Q_DEPTH - 1);

  logic [31:0]       pc_r;
  logic              f1_valid_r;
  logic [31:0]       f1_pc_r;
  logic              f1_dir_r;
  logic [31:0]       f1_target_r;
  logic [META_W-1:0] f1_meta_r;

  logic [CW-1:0]     count_r;
  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [31:0]       q_pc_r     [Q_DEPTH];
  logic [31:0]       q_inst_r   [Q_DEPTH];
  logic              q_dir_r    [Q_DEPTH];
  logic [31:0]       q_target_r [Q_DEPTH];
  logic [META_W-1:0] q_meta_r   [Q_DEPTH];

  logic [CW:0]       occ_s;
  logic              issue_s;
  logic              enq_s;
  logic              deq_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_C) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Issue decision and queue handshakes; the F1 entry reserves a slot, no credit for a same-cycle dequeue.
  always_comb begin
    occ_s   = {1'b0, count_r} + {{CW{1'b0}}, f1_valid_r};
    issue_s = redirect | (occ_s < DEPTH_C);
    enq_s   = f1_valid_r & ~redirect;
    deq_s   = out_valid & out_ready & ~redirect;
  end

  assign bp_pc        = redirect ? redirect_pc : pc_r;
  assign bp_inst      = ic_q;
  assign bp_stall     = ~issue_s;
  assign ic_rdaddress = bp_pc[IC_AW+1:2];

  assign out_valid    = (count_r != {CW{1'b0}});
  assign out_pc       = q_pc_r[head_r];
  assign out_inst     = q_inst_r[head_r];
  assign out_p_dir    = q_dir_r[head_r];
  assign out_p_target = q_target_r[head_r];
  assign out_meta     = q_meta_r[head_r];

  // Fetch PC and F1 stage registers capturing the prediction alongside the issued PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r        <= RESET_PC;
      f1_valid_r  <= 1'b0;
      f1_pc_r     <= 32'h0;
      f1_dir_r    <= 1'b0;
      f1_target_r <= 32'h0;
      f1_meta_r   <= {META_W{1'b0}};
    end else if (issue_s) begin
      pc_r        <= bp_p_target;
      f1_valid_r  <= 1'b1;
      f1_pc_r     <= bp_pc;
      f1_dir_r    <= bp_p_dir;
      f1_target_r <= bp_p_target;
      f1_meta_r   <= bp_meta;
    end else begin
      f1_valid_r  <= 1'b0;
    end
  end

  // Queue pointers and occupancy; a redirect flushes and overrides any handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {CW{1'b0}};
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
    end else if (redirect) begin
      count_r <= {CW{1'b0}};
      tail_r  <= head_r;
    end else begin
      case ({enq_s, deq_s})
        2'b10: begin
          count_r <= count_r + CW'(1);
          tail_r  <= ptr_inc(tail_r);
        end
        2'b01: begin
          count_r <= count_r - CW'(1);
          head_r  <= ptr_inc(head_r);
        end
        2'b11: begin
          head_r  <= ptr_inc(head_r);
          tail_r  <= ptr_inc(tail_r);
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Queue storage; the F1 entry is paired with the BRAM data returned this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Q_DEPTH; i++) begin
        q_pc_r[i]     <= 32'h0;
        q_inst_r[i]   <= 32'h0;
        q_dir_r[i]    <= 1'b0;
        q_target_r[i] <= 32'h0;
        q_meta_r[i]   <= {META_W{1'b0}};
      end
    end else if (enq_s) begin
      q_pc_r[tail_r]     <= f1_pc_r;
      q_inst_r[tail_r]   <= ic_q;
      q_dir_r[tail_r]    <= f1_dir_r;
      q_target_r[tail_r] <= f1_target_r;
      q_meta_r[tail_r]   <= f1_meta_r;
    end else begin
      q_pc_r[tail_r]     <= q_pc_r[tail_r];
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: BRAM and predictor models, in-order scoreboard of the
// expected fetch stream, a combinational vector table, and redirect/reset sequences.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] bp_pc;
  logic [31:0] bp_inst;
  logic        bp_stall;
  logic [31:0] bp_p_target;
  logic        bp_p_dir;
  logic [23:0] bp_meta;
  logic [7:0]  ic_rdaddress;
  logic [31:0] ic_q = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_p_dir;
  logic [31:0] out_p_target;
  logic [23:0] out_meta;

  logic br_en = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   hs_cnt = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        dir;
    logic [31:0] target;
    logic [23:0] meta;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] exp_pc;
    logic [7:0]  exp_addr;
    logic        exp_stall;
  } vec_t;
  vec_t vt[6];

  fetch_pc_gen dut (
    .clk(clk), .reset_n(reset_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .bp_pc(bp_pc), .bp_inst(bp_inst), .bp_stall(bp_stall),
    .bp_p_target(bp_p_target), .bp_p_dir(bp_p_dir), .bp_meta(bp_meta),
    .ic_rdaddress(ic_rdaddress), .ic_q(ic_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_p_dir(out_p_dir), .out_p_target(out_p_target), .out_meta(out_meta)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [7:0] a);
    return {16'hC0DE, a, ~a};
  endfunction
  function automatic logic pred_dir(input logic [31:0] pc);
    return br_en && (pc == 32'h8);
  endfunction
  function automatic logic [31:0] pred_tgt(input logic [31:0] pc);
    return pred_dir(pc) ? 32'h100 : pc + 32'd4;
  endfunction
  function automatic logic [23:0] meta_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'h5A5A, pc[31:24]};
  endfunction

  assign bp_p_dir    = pred_dir(bp_pc);
  assign bp_p_target = pred_tgt(bp_pc);
  assign bp_meta     = meta_of(bp_pc);

  always @(posedge clk) ic_q <= inst_of(ic_rdaddress);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    logic [31:0] pc;
    exp_t e;
    sb_q.delete();
    pc = start;
    for (int i = 0; i < 48; i++) begin
      e.pc = pc; e.inst = inst_of(pc[9:2]); e.dir = pred_dir(pc);
      e.target = pred_tgt(pc); e.meta = meta_of(pc);
      sb_q.push_back(e);
      pc = e.target;
    end
  endtask

  // Wait for n more handshakes, bounded; leaves time at posedge+1.
  task automatic wait_hs(input int n, input string nm);
    int target;
    int cyc;
    target = hs_cnt + n;
    cyc = 0;
    while (hs_cnt < target && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_hs_timeout"}, 64'(hs_cnt >= target), 64'd1);
  endtask

  // Scoreboard monitor: compare every accepted head against the expected stream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready && !redirect) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("out_pc", 64'(out_pc), 64'(e.pc));
          chk("out_inst", 64'(out_inst), 64'(e.inst));
          chk("out_p_dir", 64'(out_p_dir), 64'(e.dir));
          chk("out_p_target", 64'(out_p_target), 64'(e.target));
          chk("out_meta", 64'(out_meta), 64'(e.meta));
        end
      end
    end
  end

  initial begin
    int base;
    reset_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    sb_restart(32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_target", 64'(out_p_target), 64'd0);
    chk("rst_out_meta", 64'(out_meta), 64'd0);
    chk("rst_bp_pc", 64'(bp_pc), 64'd0);
    chk("rst_bp_stall", 64'(bp_stall), 64'd0);

    // Latency from reset release: first head visible two cycles after first issue.
    base = hs_cnt;
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("lat_t1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_t2_valid", 64'(out_valid), 64'd1);
    chk("lat_t2_pc", 64'(out_pc), 64'd0);
    chk("bp_inst_eq_icq", 64'(bp_inst), 64'(ic_q));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stream_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    chk("stream_hs_count", 64'(hs_cnt - base), 64'd4);

    // Back-pressure: queue fills, issue stops.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) chk("bp_stall_full", 64'(bp_stall), 64'd1);
    end
    chk("full_valid", 64'(out_valid), 64'd1);

    // Combinational issue-path vectors applied mid-cycle while the queue is full.
    vt[0] = '{1'b0, 32'h0,         sb_q[3].pc,   sb_q[3].pc[9:2], 1'b1};
    vt[1] = '{1'b1, 32'h0000_0040, 32'h0000_0040, 8'h10,          1'b0};
    vt[2] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF,          1'b0};
    vt[3] = '{1'b1, 32'h0000_0401, 32'h0000_0401, 8'h00,          1'b0};
    vt[4] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 8'h9E,          1'b0};
    vt[5] = '{1'b0, 32'hDEAD_BEEF, sb_q[3].pc,   sb_q[3].pc[9:2], 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      redirect = vt[i].redir; redirect_pc = vt[i].rpc;
      #1;
      chk("vec_bp_pc", 64'(bp_pc), 64'(vt[i].exp_pc));
      chk("vec_ic_addr", 64'(ic_rdaddress), 64'(vt[i].exp_addr));
      chk("vec_bp_stall", 64'(bp_stall), 64'(vt[i].exp_stall));
      redirect = 1'b0;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_hs(6, "release");

    // Redirect with two queued entries and a would-be handshake.
    out_ready = 1'b0;
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    sb_restart(32'h40);
    base = hs_cnt;
    @(negedge clk);
    chk("redir_head_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("redir_next_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("redir_t2_valid", 64'(out_valid), 64'd1);
    chk("redir_t2_pc", 64'(out_pc), 64'h40);
    chk("redir_no_old_hs", 64'(hs_cnt - base), 64'd1);
    @(posedge clk); #1;
    wait_hs(3, "redir_stream");

    // Predicted-taken branch at 0x8.
    redirect = 1'b1; redirect_pc = 32'h0; br_en = 1'b1;
    sb_restart(32'h0);
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_hs(7, "taken");

    // PC wrap through 2**32.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; br_en = 1'b0;
    sb_restart(32'hFFFF_FFF8);
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_hs(4, "wrap");

    // Asynchronous reset mid-stream.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_pc", 64'(out_pc), 64'd0);
    chk("async_rst_bp_pc", 64'(bp_pc), 64'd0);
    sb_restart(32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_hs(5, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
